// File: rtl/divide_iterative.sv
// rtl/divide_iterative.sv - restoring divider, one quotient bit per clock, valid/ready in and out
// Optional round-half-up stage enabled by defining DIVIDE_ITERATIVE_ROUND_EN.
module divide_iterative #(
   parameter int N_WIDTH = 64,
   parameter int D_WIDTH = 32,
   parameter int Q_WIDTH = 32
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               In_Valid,
   output logic               In_Ready,
   input  logic [N_WIDTH-1:0] A,
   input  logic [D_WIDTH-1:0] B,
   output logic               Out_Valid,
   input  logic               Out_Ready,
   output logic [Q_WIDTH-1:0] Q,
   output logic [D_WIDTH-1:0] R,
   output logic               DivZero,
   output logic               Overflow,
   output logic               Busy
);

   localparam int DEN_W = D_WIDTH + Q_WIDTH - 1;
   localparam int W     = (N_WIDTH > DEN_W) ? N_WIDTH : DEN_W;
   localparam int CNT_W = $clog2(Q_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ROUND, S_DONE} state_t;

   state_t             state, next_state;
   logic [W-1:0]       rem, den, rem_nxt, a_w, b_w;
   logic [CNT_W-1:0]   count;
   logic               ready_q, accept, b_zero, ovf, sub_ok, last_iter;
`ifdef DIVIDE_ITERATIVE_ROUND_EN
   logic [D_WIDTH-1:0] b_reg;
   logic               round_up;
   assign round_up = {R, 1'b0} >= {1'b0, b_reg};
`endif

   assign a_w       = W'(A);
   assign b_w       = W'(B);
   assign accept    = In_Valid & In_Ready;
   assign b_zero    = (B == '0);
   // High part of A not below B means the quotient cannot fit in Q_WIDTH bits.
   assign ovf       = (a_w >> Q_WIDTH) >= b_w;
   assign sub_ok    = den <= rem;
   assign rem_nxt   = sub_ok ? rem - den : rem;
   assign last_iter = (count == CNT_W'(Q_WIDTH - 1));

   assign In_Ready  = ready_q;
   assign Out_Valid = (state == S_DONE);
   assign Busy      = (state != S_IDLE);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = (b_zero || ovf) ? S_DONE : S_RUN;
`ifdef DIVIDE_ITERATIVE_ROUND_EN
         S_RUN:   if (last_iter) next_state = S_ROUND;
`else
         S_RUN:   if (last_iter) next_state = S_DONE;
`endif
         S_ROUND: next_state = S_DONE;
         S_DONE:  if (Out_Ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state    <= S_IDLE;
         ready_q  <= 1'b0;
         rem      <= '0;
         den      <= '0;
         count    <= '0;
         Q        <= '0;
         R        <= '0;
         DivZero  <= 1'b0;
         Overflow <= 1'b0;
`ifdef DIVIDE_ITERATIVE_ROUND_EN
         b_reg    <= '0;
`endif
      end else begin
         state   <= next_state;
         ready_q <= (next_state == S_IDLE);
         case (state)
            S_IDLE: if (accept) begin
               rem   <= a_w;
               den   <= b_w << (Q_WIDTH - 1);
               count <= '0;
               Q     <= '0;
`ifdef DIVIDE_ITERATIVE_ROUND_EN
               b_reg <= B;
`endif
               if (b_zero) begin
                  Q        <= '1;
                  R        <= a_w[D_WIDTH-1:0];
                  DivZero  <= 1'b1;
                  Overflow <= 1'b0;
               end else if (ovf) begin
                  Q        <= '1;
                  R        <= '0;
                  DivZero  <= 1'b0;
                  Overflow <= 1'b1;
               end
            end
            S_RUN: begin
               Q     <= {Q[Q_WIDTH-2:0], sub_ok};
               rem   <= rem_nxt;
               den   <= den >> 1;
               count <= count + CNT_W'(1);
               if (last_iter) begin
                  R        <= rem_nxt[D_WIDTH-1:0];
                  DivZero  <= 1'b0;
                  Overflow <= 1'b0;
               end
            end
`ifdef DIVIDE_ITERATIVE_ROUND_EN
            // Rounding an all-ones quotient would wrap, so saturate and flag instead.
            S_ROUND: if (round_up) begin
               if (&Q) Overflow <= 1'b1;
               else    Q        <= Q + Q_WIDTH'(1);
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divide_iterative.sv
// tb/tb_divide_iterative.sv - randomized and directed checks of divide_iterative against an arithmetic model
module tb_divide_iterative;

   logic        Clk = 1'b0;
   logic        nReset = 1'b0;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [63:0] A = '0;
   logic [31:0] B = '0;
   logic        Out_Valid;
   logic        Out_Ready = 1'b0;
   logic [31:0] Q;
   logic [31:0] R;
   logic        DivZero;
   logic        Overflow;
   logic        Busy;

   int n_tests = 0;
   int n_fail  = 0;

   divide_iterative #(.N_WIDTH(64), .D_WIDTH(32), .Q_WIDTH(32)) dut (
      .Clk(Clk), .nReset(nReset), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Q(Q), .R(R), .DivZero(DivZero), .Overflow(Overflow), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output logic ov, output int lat);
      logic [63:0] quo;
      dz = 1'b0; ov = 1'b0;
      if (b == 0) begin
         q = '1; r = a[31:0]; dz = 1'b1; lat = 1;
      end else begin
         quo = a / {32'd0, b};
         if (quo > 64'hFFFF_FFFF) begin
            q = '1; r = '0; ov = 1'b1; lat = 1;
         end else begin
            q = quo[31:0];
            r = 32'(a % {32'd0, b});
            lat = 33;
`ifdef DIVIDE_ITERATIVE_ROUND_EN
            lat = 34;
            if (2 * {32'd0, r} >= {32'd0, b}) begin
               if (q == 32'hFFFF_FFFF) ov = 1'b1;
               else q = q + 1;
            end
`endif
         end
      end
   endfunction

   // Issue one job, wait for the result, optionally stall the consumer, then complete the handshake.
   task automatic do_div(input logic [63:0] a, input logic [31:0] b, input int hold);
      logic [31:0] eq, er;
      logic        edz, eov;
      int          elat, lat;
      model(a, b, eq, er, edz, eov, elat);
      @(negedge Clk);
      chk("in_ready_idle", In_Ready, 1);
      A = a; B = b; In_Valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      In_Valid = 1'b0;
      A = {$urandom, $urandom}; B = $urandom;
      lat = 1;
      while (!Out_Valid && lat < 200) begin
         @(negedge Clk);
         lat++;
      end
      chk($sformatf("latency %0h/%0h", a, b), lat, elat);
      chk($sformatf("q %0h/%0h", a, b), Q, eq);
      chk($sformatf("r %0h/%0h", a, b), R, er);
      chk($sformatf("divzero %0h/%0h", a, b), DivZero, edz);
      chk($sformatf("overflow %0h/%0h", a, b), Overflow, eov);
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         chk("hold_valid", Out_Valid, 1);
         chk("hold_q", Q, eq);
         chk("hold_r", R, er);
         chk("hold_in_ready", In_Ready, 0);
      end
      Out_Ready = 1'b1;
      @(negedge Clk);
      Out_Ready = 1'b0;
      chk("valid_drop", Out_Valid, 0);
      chk("ready_back", In_Ready, 1);
      chk("flags_hold", {DivZero, Overflow}, {edz, eov});
   endtask

   initial begin
      logic [63:0] ra;
      logic [31:0] rb;
      #2;
      chk("rst_q", Q, 0);
      chk("rst_r", R, 0);
      chk("rst_flags", {DivZero, Overflow, Out_Valid, Busy}, 0);
      chk("rst_in_ready", In_Ready, 0);
      @(negedge Clk);
      nReset = 1'b1;
      @(negedge Clk);
      chk("in_ready_after_release", In_Ready, 1);

      do_div(64'd100, 32'd7, 0);
      do_div(64'h0000_0000_FFFF_FFFF, 32'd1, 0);
      do_div(64'h0000_0001_0000_0000, 32'd1, 0);
      do_div(64'd5, 32'd0, 0);
      do_div(64'd11, 32'd4, 10);
      do_div(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_div(64'd3, 32'd2, 0);

      // Leave DivZero set, then kill a job mid-run.
      do_div(64'd5, 32'd0, 0);
      @(negedge Clk);
      A = 64'd1000; B = 32'd3; In_Valid = 1'b1;
      @(negedge Clk);
      In_Valid = 1'b0;
      chk("busy_in_run", Busy, 1);
      repeat (14) @(negedge Clk);
      nReset = 1'b0;
      #1;
      chk("async_rst_q", Q, 0);
      chk("async_rst_r", R, 0);
      chk("async_rst_flags", {DivZero, Overflow, Out_Valid, Busy}, 0);
      chk("async_rst_in_ready", In_Ready, 0);
      @(negedge Clk);
      nReset = 1'b1;
      repeat (40) begin
         @(negedge Clk);
         if (Out_Valid) chk("discarded_job_emitted", Out_Valid, 0);
      end
      do_div(64'd9, 32'd3, 0);

      for (int i = 0; i < 24; i++) begin
         ra = {$urandom, $urandom} >> $urandom_range(0, 63);
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) rb = 0;
         do_div(ra, rb, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
